// File: rtl/tlb_mmu.sv
`default_nettype none
// ============================================================================
// Module      : tlb_mmu
// Description : MIPS32-style joint TLB. Executes TLBR/TLBWI/TLBWR/TLBP from
//               CP0 register values, returns TLBR/TLBP results as one-cycle
//               write-back pulses, and translates fetch and data addresses
//               combinationally with refill/invalid/modified flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_mmu #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  tlb_op_i,
    input  logic [31:0] index_i,
    input  logic [31:0] random_i,
    input  logic [31:0] entryhi_i,
    input  logic [31:0] entrylo0_i,
    input  logic [31:0] entrylo1_i,
    input  logic [31:0] pagemask_i,
    output logic        r_we_o,
    output logic [31:0] r_entryhi_o,
    output logic [31:0] r_entrylo0_o,
    output logic [31:0] r_entrylo1_o,
    output logic [31:0] r_pagemask_o,
    output logic        p_we_o,
    output logic [31:0] p_index_o,
    input  logic        i_req_i,
    input  logic [31:0] i_vaddr_i,
    output logic [31:0] i_paddr_o,
    output logic        i_miss_o,
    output logic        i_invalid_o,
    input  logic        d_req_i,
    input  logic        d_write_i,
    input  logic [31:0] d_vaddr_i,
    output logic [31:0] d_paddr_o,
    output logic        d_miss_o,
    output logic        d_invalid_o,
    output logic        d_modified_o
);

    localparam logic [2:0] c_op_tlbr  = 3'b001;
    localparam logic [2:0] c_op_tlbwi = 3'b010;
    localparam logic [2:0] c_op_tlbwr = 3'b011;
    localparam logic [2:0] c_op_tlbp  = 3'b100;

    typedef struct packed {
        logic        used;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
        logic [15:0] mask;
    } entry_t;

    entry_t tlb_q [ENTRIES];
    entry_t tlb_d [ENTRIES];

    logic        r_we_q, r_we_d;
    logic [31:0] r_entryhi_q, r_entryhi_d;
    logic [31:0] r_entrylo0_q, r_entrylo0_d;
    logic [31:0] r_entrylo1_q, r_entrylo1_d;
    logic [31:0] r_pagemask_q, r_pagemask_d;
    logic        p_we_q, p_we_d;
    logic [31:0] p_index_q, p_index_d;

    logic [ENTRIES-1:0] w_i_vec, w_d_vec, w_p_vec;
    logic [IDX_W-1:0]   w_i_idx, w_d_idx, w_p_idx;
    entry_t             w_i_ent, w_d_ent, w_r_ent;
    logic [IDX_W-1:0]   w_wr_idx;

    // Lowest matching index wins when several entries alias
    function automatic logic [IDX_W-1:0] first_hit(input logic [ENTRIES-1:0] vec);
        first_hit = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            if (vec[k]) first_hit = IDX_W'(k);
        end
    endfunction

    // Per-entry match against fetch, data and probe lookups (ASID always from EntryHi)
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_match
            assign w_i_vec[gi] = tlb_q[gi].used && (tlb_q[gi].vpn2 == i_vaddr_i[31:13]) &&
                                 (tlb_q[gi].g || (tlb_q[gi].asid == entryhi_i[7:0]));
            assign w_d_vec[gi] = tlb_q[gi].used && (tlb_q[gi].vpn2 == d_vaddr_i[31:13]) &&
                                 (tlb_q[gi].g || (tlb_q[gi].asid == entryhi_i[7:0]));
            assign w_p_vec[gi] = tlb_q[gi].used && (tlb_q[gi].vpn2 == entryhi_i[31:13]) &&
                                 (tlb_q[gi].g || (tlb_q[gi].asid == entryhi_i[7:0]));
        end
    endgenerate

    assign w_i_idx  = first_hit(w_i_vec);
    assign w_d_idx  = first_hit(w_d_vec);
    assign w_p_idx  = first_hit(w_p_vec);
    assign w_i_ent  = tlb_q[w_i_idx];
    assign w_d_ent  = tlb_q[w_d_idx];
    assign w_r_ent  = tlb_q[index_i[IDX_W-1:0]];
    assign w_wr_idx = (tlb_op_i == c_op_tlbwr) ? random_i[IDX_W-1:0] : index_i[IDX_W-1:0];

    // Entry array next state: TLBWI/TLBWR overwrite one entry
    always_comb begin
        tlb_d = tlb_q;
        if ((tlb_op_i == c_op_tlbwi) || (tlb_op_i == c_op_tlbwr)) begin
            tlb_d[w_wr_idx].used = 1'b1;
            tlb_d[w_wr_idx].vpn2 = entryhi_i[31:13];
            tlb_d[w_wr_idx].asid = entryhi_i[7:0];
            tlb_d[w_wr_idx].g    = entrylo0_i[0] & entrylo1_i[0];
            tlb_d[w_wr_idx].pfn0 = entrylo0_i[25:6];
            tlb_d[w_wr_idx].c0   = entrylo0_i[5:3];
            tlb_d[w_wr_idx].d0   = entrylo0_i[2];
            tlb_d[w_wr_idx].v0   = entrylo0_i[1];
            tlb_d[w_wr_idx].pfn1 = entrylo1_i[25:6];
            tlb_d[w_wr_idx].c1   = entrylo1_i[5:3];
            tlb_d[w_wr_idx].d1   = entrylo1_i[2];
            tlb_d[w_wr_idx].v1   = entrylo1_i[1];
            tlb_d[w_wr_idx].mask = pagemask_i[28:13];
        end
    end

    // TLBR/TLBP result registers: pulses last one cycle, data holds afterwards
    always_comb begin
        r_we_d       = (tlb_op_i == c_op_tlbr);
        r_entryhi_d  = r_entryhi_q;
        r_entrylo0_d = r_entrylo0_q;
        r_entrylo1_d = r_entrylo1_q;
        r_pagemask_d = r_pagemask_q;
        p_we_d       = (tlb_op_i == c_op_tlbp);
        p_index_d    = p_index_q;
        if (tlb_op_i == c_op_tlbr) begin
            if (w_r_ent.used) begin
                r_entryhi_d  = {w_r_ent.vpn2, 5'b0, w_r_ent.asid};
                r_entrylo0_d = {6'b0, w_r_ent.pfn0, w_r_ent.c0, w_r_ent.d0, w_r_ent.v0, w_r_ent.g};
                r_entrylo1_d = {6'b0, w_r_ent.pfn1, w_r_ent.c1, w_r_ent.d1, w_r_ent.v1, w_r_ent.g};
                r_pagemask_d = {3'b0, w_r_ent.mask, 13'b0};
            end else begin
                r_entryhi_d  = '0;
                r_entrylo0_d = '0;
                r_entrylo1_d = '0;
                r_pagemask_d = '0;
            end
        end
        if (tlb_op_i == c_op_tlbp) begin
            p_index_d = (|w_p_vec) ? {{(32-IDX_W){1'b0}}, w_p_idx} : 32'h8000_0000;
        end
    end

    // State registers with asynchronous clear of the whole array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) tlb_q[k] <= '0;
            r_we_q       <= 1'b0;
            r_entryhi_q  <= '0;
            r_entrylo0_q <= '0;
            r_entrylo1_q <= '0;
            r_pagemask_q <= '0;
            p_we_q       <= 1'b0;
            p_index_q    <= '0;
        end else begin
            tlb_q        <= tlb_d;
            r_we_q       <= r_we_d;
            r_entryhi_q  <= r_entryhi_d;
            r_entrylo0_q <= r_entrylo0_d;
            r_entrylo1_q <= r_entrylo1_d;
            r_pagemask_q <= r_pagemask_d;
            p_we_q       <= p_we_d;
            p_index_q    <= p_index_d;
        end
    end

    // Fetch translation: kseg0/1 bypass, otherwise even/odd page select on va[12]
    always_comb begin
        i_paddr_o   = '0;
        i_miss_o    = 1'b0;
        i_invalid_o = 1'b0;
        if (i_vaddr_i[31:30] == 2'b10) begin
            i_paddr_o = {3'b000, i_vaddr_i[28:0]};
        end else begin
            if (|w_i_vec) begin
                i_paddr_o = {(i_vaddr_i[12] ? w_i_ent.pfn1 : w_i_ent.pfn0), i_vaddr_i[11:0]};
            end
            i_miss_o    = i_req_i & ~(|w_i_vec);
            i_invalid_o = i_req_i & (|w_i_vec) & ~(i_vaddr_i[12] ? w_i_ent.v1 : w_i_ent.v0);
        end
    end

    // Data translation: same as fetch plus store-to-clean-page detection
    always_comb begin
        d_paddr_o    = '0;
        d_miss_o     = 1'b0;
        d_invalid_o  = 1'b0;
        d_modified_o = 1'b0;
        if (d_vaddr_i[31:30] == 2'b10) begin
            d_paddr_o = {3'b000, d_vaddr_i[28:0]};
        end else begin
            if (|w_d_vec) begin
                d_paddr_o = {(d_vaddr_i[12] ? w_d_ent.pfn1 : w_d_ent.pfn0), d_vaddr_i[11:0]};
            end
            d_miss_o     = d_req_i & ~(|w_d_vec);
            d_invalid_o  = d_req_i & (|w_d_vec) & ~(d_vaddr_i[12] ? w_d_ent.v1 : w_d_ent.v0);
            d_modified_o = d_req_i & d_write_i & (|w_d_vec) &
                           (d_vaddr_i[12] ? w_d_ent.v1 : w_d_ent.v0) &
                           ~(d_vaddr_i[12] ? w_d_ent.d1 : w_d_ent.d0);
        end
    end

    assign r_we_o       = r_we_q;
    assign r_entryhi_o  = r_entryhi_q;
    assign r_entrylo0_o = r_entrylo0_q;
    assign r_entrylo1_o = r_entrylo1_q;
    assign r_pagemask_o = r_pagemask_q;
    assign p_we_o       = p_we_q;
    assign p_index_o    = p_index_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_mmu.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_mmu
// Description : Scoreboard bench for tlb_mmu. Stimulus pushes expected
//               translations and write-back pulses into queues; a monitor on
//               the falling edge pops and compares whenever the DUT presents
//               a result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_mmu;

    localparam logic [2:0] c_tlbr  = 3'b001;
    localparam logic [2:0] c_tlbwi = 3'b010;
    localparam logic [2:0] c_tlbwr = 3'b011;
    localparam logic [2:0] c_tlbp  = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  tlb_op_i = '0;
    logic [31:0] index_i = '0, random_i = '0, entryhi_i = '0;
    logic [31:0] entrylo0_i = '0, entrylo1_i = '0, pagemask_i = '0;
    logic        r_we_o, p_we_o;
    logic [31:0] r_entryhi_o, r_entrylo0_o, r_entrylo1_o, r_pagemask_o, p_index_o;
    logic        i_req_i = 1'b0;
    logic [31:0] i_vaddr_i = '0;
    logic [31:0] i_paddr_o;
    logic        i_miss_o, i_invalid_o;
    logic        d_req_i = 1'b0, d_write_i = 1'b0;
    logic [31:0] d_vaddr_i = '0;
    logic [31:0] d_paddr_o;
    logic        d_miss_o, d_invalid_o, d_modified_o;

    typedef struct packed {
        logic [31:0] pa;
        logic        miss;
        logic        inv;
        logic        mod;
    } xl_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
        logic [31:0] pm;
    } rd_t;

    xl_t         iq[$];
    xl_t         dq[$];
    rd_t         rq[$];
    logic [31:0] pq[$];

    int tests  = 0;
    int failed = 0;

    tlb_mmu #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .tlb_op_i(tlb_op_i),
        .index_i(index_i), .random_i(random_i), .entryhi_i(entryhi_i),
        .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i), .pagemask_i(pagemask_i),
        .r_we_o(r_we_o), .r_entryhi_o(r_entryhi_o), .r_entrylo0_o(r_entrylo0_o),
        .r_entrylo1_o(r_entrylo1_o), .r_pagemask_o(r_pagemask_o),
        .p_we_o(p_we_o), .p_index_o(p_index_o),
        .i_req_i(i_req_i), .i_vaddr_i(i_vaddr_i), .i_paddr_o(i_paddr_o),
        .i_miss_o(i_miss_o), .i_invalid_o(i_invalid_o),
        .d_req_i(d_req_i), .d_write_i(d_write_i), .d_vaddr_i(d_vaddr_i),
        .d_paddr_o(d_paddr_o), .d_miss_o(d_miss_o), .d_invalid_o(d_invalid_o),
        .d_modified_o(d_modified_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented result against the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (i_req_i) begin
                if (iq.size() == 0) chk("i_unexpected", 32'd1, 32'd0);
                else begin
                    xl_t e;
                    e = iq.pop_front();
                    chk("i_paddr", i_paddr_o, e.pa);
                    chk("i_flags", {30'd0, i_miss_o, i_invalid_o}, {30'd0, e.miss, e.inv});
                end
            end
            if (d_req_i) begin
                if (dq.size() == 0) chk("d_unexpected", 32'd1, 32'd0);
                else begin
                    xl_t e;
                    e = dq.pop_front();
                    chk("d_paddr", d_paddr_o, e.pa);
                    chk("d_flags", {29'd0, d_miss_o, d_invalid_o, d_modified_o},
                        {29'd0, e.miss, e.inv, e.mod});
                end
            end
            if (r_we_o) begin
                if (rq.size() == 0) chk("r_we_unexpected", 32'd1, 32'd0);
                else begin
                    rd_t e;
                    e = rq.pop_front();
                    chk("r_entryhi", r_entryhi_o, e.hi);
                    chk("r_entrylo0", r_entrylo0_o, e.lo0);
                    chk("r_entrylo1", r_entrylo1_o, e.lo1);
                    chk("r_pagemask", r_pagemask_o, e.pm);
                end
            end
            if (p_we_o) begin
                if (pq.size() == 0) chk("p_we_unexpected", 32'd1, 32'd0);
                else chk("p_index", p_index_o, pq.pop_front());
            end
        end
    end

    task automatic op(input logic [2:0] code, input logic [31:0] idx, input logic [31:0] hi,
                      input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] pm);
        tlb_op_i   = code;
        index_i    = idx;
        random_i   = idx;
        entryhi_i  = hi;
        entrylo0_i = lo0;
        entrylo1_i = lo1;
        pagemask_i = pm;
        @(posedge clk);
        #1 tlb_op_i = 3'b000;
    endtask

    task automatic rd(input logic [31:0] idx, input rd_t e);
        rq.push_back(e);
        op(c_tlbr, idx, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic probe(input logic [31:0] hi, input logic [31:0] e);
        pq.push_back(e);
        op(c_tlbp, 32'd0, hi, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic xi(input logic [31:0] va, input logic [7:0] asid, input xl_t e);
        entryhi_i[7:0] = asid;
        i_vaddr_i      = va;
        i_req_i        = 1'b1;
        iq.push_back(e);
        @(posedge clk);
        #1 i_req_i = 1'b0;
    endtask

    task automatic xd(input logic [31:0] va, input logic wr, input logic [7:0] asid, input xl_t e);
        entryhi_i[7:0] = asid;
        d_vaddr_i      = va;
        d_write_i      = wr;
        d_req_i        = 1'b1;
        dq.push_back(e);
        @(posedge clk);
        #1 d_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_r_we", {31'd0, r_we_o}, 32'd0);
        chk("rst_p_we", {31'd0, p_we_o}, 32'd0);
        chk("rst_r_entryhi", r_entryhi_o, 32'd0);
        chk("rst_p_index", p_index_o, 32'd0);
        @(posedge clk);
        #1;

        // Empty TLB: mapped miss, kseg0/kseg1 bypass, no flag without request
        xi(32'h0000_0000, 8'h00, '{32'h0, 1'b1, 1'b0, 1'b0});
        xi(32'h8000_1234, 8'h00, '{32'h0000_1234, 1'b0, 1'b0, 1'b0});
        xi(32'hA000_1234, 8'h00, '{32'h0000_1234, 1'b0, 1'b0, 1'b0});
        i_vaddr_i = 32'h0000_0000;
        #1 chk("i_noreq_miss", {31'd0, i_miss_o}, 32'd0);

        // Entry 3: even page PFN 4 valid+dirty, odd page PFN 5 invalid
        op(c_tlbwi, 32'd3, 32'h0040_0005, 32'h0000_0106, 32'h0000_0140, 32'd0);
        xd(32'h0040_0ABC, 1'b0, 8'h05, '{32'h0000_4ABC, 1'b0, 1'b0, 1'b0});
        xd(32'h0040_1ABC, 1'b0, 8'h05, '{32'h0000_5ABC, 1'b0, 1'b1, 1'b0});
        xi(32'h0040_0ABC, 8'h05, '{32'h0000_4ABC, 1'b0, 1'b0, 1'b0});

        // Entry 3 rewritten with clean even page
        op(c_tlbwi, 32'd3, 32'h0040_0005, 32'h0000_0102, 32'h0000_0140, 32'd0);
        xd(32'h0040_0000, 1'b1, 8'h05, '{32'h0000_4000, 1'b0, 1'b0, 1'b1});
        xd(32'h0040_0000, 1'b0, 8'h05, '{32'h0000_4000, 1'b0, 1'b0, 1'b0});
        xd(32'h0040_0000, 1'b0, 8'h06, '{32'h0000_0000, 1'b1, 1'b0, 1'b0});

        // Probe hit and miss
        probe(32'h0040_0005, 32'h0000_0003);
        probe(32'h0080_0005, 32'h8000_0000);

        // TLBWR via Random[3:0]=15, then read back; G is the AND (0 here)
        op(c_tlbwr, 32'h0000_001F, 32'h1234_E0AB, 32'h0123_4567, 32'h0000_00C6, 32'h0001_E000);
        rd(32'd15, '{32'h1234_E0AB, 32'h0123_4566, 32'h0000_00C6, 32'h0001_E000});
        rd(32'd7, '{32'h0, 32'h0, 32'h0, 32'h0});

        // Global entry 5 hits regardless of ASID; store to dirty page is clean
        op(c_tlbwi, 32'd5, 32'h0100_0009, 32'h0000_0087, 32'h0000_0001, 32'd0);
        xd(32'h0100_0123, 1'b1, 8'h33, '{32'h0000_2123, 1'b0, 1'b0, 1'b0});
        rd(32'd5, '{32'h0100_0009, 32'h0000_0087, 32'h0000_0001, 32'h0});

        // Aliased entries 2 and 9 back-to-back; lowest index wins
        op(c_tlbwi, 32'd9, 32'h0300_0001, 32'h0000_02C6, 32'd0, 32'd0);
        op(c_tlbwi, 32'd2, 32'h0300_0001, 32'h0000_0286, 32'd0, 32'd0);
        probe(32'h0300_0001, 32'h0000_0002);
        xd(32'h0300_0010, 1'b0, 8'h01, '{32'h0000_A010, 1'b0, 1'b0, 1'b0});

        // Asynchronous reset during a TLBR drops the pulse and clears the array
        @(posedge clk);
        #1;
        tlb_op_i = c_tlbr;
        index_i  = 32'd15;
        #2 rst = 1'b1;
        @(posedge clk);
        #1 tlb_op_i = 3'b000;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_r_we", {31'd0, r_we_o}, 32'd0);
        chk("rst_mid_r_entryhi", r_entryhi_o, 32'd0);
        @(posedge clk);
        #1;
        xd(32'h0040_0ABC, 1'b0, 8'h05, '{32'h0000_0000, 1'b1, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        chk("i_queue_drained", iq.size(), 32'd0);
        chk("d_queue_drained", dq.size(), 32'd0);
        chk("r_queue_drained", rq.size(), 32'd0);
        chk("p_queue_drained", pq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
